// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared defaults and counter-width helper for input_conditioner
package input_cond_pkg;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  // Counter must hold 0..n-1; never narrower than 1 bit
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/debounce_lane.sv
// debounce_lane: one input lane - synchroniser, debounce counter, stable level, edge flags
// Ports: clk, rst_n (async active-low), ena (pulse gate sampled at the flip edge),
//        din (raw pin), level (debounced), rise/fall (one-cycle registered pulses)
module debounce_lane
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic s;
  assign s = sync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) cnt <= '0;
      else if (cnt != CMAX) cnt <= cnt + CW'(1);
      else begin
        // mismatch persisted long enough: accept it and flag the edge
        level <= s;
        cnt   <= '0;
        rise  <= s & ena;
        fall  <= ~s & ena;
      end
    end
  end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: per-lane synchronise, debounce and edge-detect of raw input pins
// Ports: clk, rst_n (async active-low), ena (gates rise/fall only), ui_in (raw pins),
//        level (debounced levels), rise/fall (one-cycle edge pulses)
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] ui_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    debounce_lane #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .ena(ena),
      .din(ui_in[i]),
      .level(level[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed self-checking bench for input_conditioner
module tb_input_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] level, rise, fall;
  int n_cmp = 0;
  int n_err = 0;

  input_conditioner dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .ui_in(ui_in),
    .level(level),
    .rise(rise),
    .fall(fall)
  );

  always #2 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    ui_in = 8'h00;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ui_in = 8'hFF;
    repeat (3) tick();
    n_cmp += 3;
    if (level !== 8'h00) begin n_err++; $display("FAIL reset_level got=%h exp=00", level); end
    if (rise !== 8'h00) begin n_err++; $display("FAIL reset_rise got=%h exp=00", rise); end
    if (fall !== 8'h00) begin n_err++; $display("FAIL reset_fall got=%h exp=00", fall); end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_cmp += 3;
      if (level !== ((e >= 6) ? 8'hFF : 8'h00)) begin n_err++; $display("FAIL reset_release_level e%0d got=%h", e, level); end
      if (rise !== ((e == 6) ? 8'hFF : 8'h00)) begin n_err++; $display("FAIL reset_release_rise e%0d got=%h", e, rise); end
      if (fall !== 8'h00) begin n_err++; $display("FAIL reset_release_fall e%0d got=%h exp=00", e, fall); end
    end
    settle();
  endtask

  task automatic test_clean_step();
    ui_in[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_cmp += 3;
      if (level !== ((e >= 6) ? 8'h01 : 8'h00)) begin n_err++; $display("FAIL step_up_level e%0d got=%h", e, level); end
      if (rise !== ((e == 6) ? 8'h01 : 8'h00)) begin n_err++; $display("FAIL step_up_rise e%0d got=%h", e, rise); end
      if (fall !== 8'h00) begin n_err++; $display("FAIL step_up_fall e%0d got=%h exp=00", e, fall); end
    end
    ui_in[0] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_cmp += 3;
      if (level !== ((e >= 6) ? 8'h00 : 8'h01)) begin n_err++; $display("FAIL step_dn_level e%0d got=%h", e, level); end
      if (rise !== 8'h00) begin n_err++; $display("FAIL step_dn_rise e%0d got=%h exp=00", e, rise); end
      if (fall !== ((e == 6) ? 8'h01 : 8'h00)) begin n_err++; $display("FAIL step_dn_fall e%0d got=%h", e, fall); end
    end
    settle();
  endtask

  task automatic test_glitch(input int w);
    logic [7:0] el, er, ef;
    ui_in[1] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      el = (w >= 4 && e >= 6 && e <= 9) ? 8'h02 : 8'h00;
      er = (w >= 4 && e == 6) ? 8'h02 : 8'h00;
      ef = (w >= 4 && e == 10) ? 8'h02 : 8'h00;
      n_cmp += 3;
      if (level !== el) begin n_err++; $display("FAIL glitch%0d_level e%0d got=%h exp=%h", w, e, level, el); end
      if (rise !== er) begin n_err++; $display("FAIL glitch%0d_rise e%0d got=%h exp=%h", w, e, rise, er); end
      if (fall !== ef) begin n_err++; $display("FAIL glitch%0d_fall e%0d got=%h exp=%h", w, e, fall, ef); end
      if (e == w) ui_in[1] = 1'b0;
    end
    settle();
  endtask

  task automatic test_bounce();
    ui_in[2] = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      n_cmp += 3;
      if (level !== ((e >= 16) ? 8'h04 : 8'h00)) begin n_err++; $display("FAIL bounce_level e%0d got=%h", e, level); end
      if (rise !== ((e == 16) ? 8'h04 : 8'h00)) begin n_err++; $display("FAIL bounce_rise e%0d got=%h", e, rise); end
      if (fall !== 8'h00) begin n_err++; $display("FAIL bounce_fall e%0d got=%h exp=00", e, fall); end
      if (e < 10) ui_in[2] = ~ui_in[2];
      else ui_in[2] = 1'b1;
    end
    settle();
  endtask

  task automatic test_ena_gating();
    ena = 1'b0;
    ui_in[3] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      n_cmp += 2;
      if (level !== ((e >= 6) ? 8'h08 : 8'h00)) begin n_err++; $display("FAIL ena_level e%0d got=%h", e, level); end
      if (rise !== 8'h00) begin n_err++; $display("FAIL ena_rise e%0d got=%h exp=00", e, rise); end
    end
    ena = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_cmp += 2;
      if (level !== 8'h08) begin n_err++; $display("FAIL ena_late_level e%0d got=%h exp=08", e, level); end
      if (rise !== 8'h00) begin n_err++; $display("FAIL ena_late_rise e%0d got=%h exp=00", e, rise); end
    end
    settle();
  endtask

  task automatic test_reset_mid(input int at);
    ui_in[4] = 1'b1;
    repeat (at) tick();
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (level !== 8'h00) begin n_err++; $display("FAIL mid%0d_level got=%h exp=00", at, level); end
    if (rise !== 8'h00) begin n_err++; $display("FAIL mid%0d_rise got=%h exp=00", at, rise); end
    if (fall !== 8'h00) begin n_err++; $display("FAIL mid%0d_fall got=%h exp=00", at, fall); end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_cmp += 2;
      if (level !== ((e >= 6) ? 8'h10 : 8'h00)) begin n_err++; $display("FAIL mid%0d_level e%0d got=%h", at, e, level); end
      if (rise !== ((e == 6) ? 8'h10 : 8'h00)) begin n_err++; $display("FAIL mid%0d_rise e%0d got=%h", at, e, rise); end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch(3);
    test_glitch(4);
    test_bounce();
    test_ena_gating();
    test_reset_mid(2);
    test_reset_mid(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
